// File: rtl/pulse_rr_distributor.sv
// Round-robin trigger distributor.
// Each trigger pulse goes to one of N_CH channels. The search starts at ptr
// and wraps from N_CH-1 back to 0. Masked channels are always skipped.
// mode 0 keeps a strict rotation: it drops the pulse when the next enabled
// channel is busy. mode 1 skips busy channels.
// Each channel is held busy for HOLD cycles after a dispatch.
// Dispatched and dropped pulses are counted with saturating counters.
module pulse_rr_distributor #(
  parameter int N_CH   = 4,
  parameter int PTR_W  = 2,
  parameter int HOLD   = 8,
  parameter int HOLD_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in,
  input  logic [N_CH-1:0]  ch_en,
  input  logic             mode,
  input  logic             clr_cnt,
  output logic [N_CH-1:0]  out,
  output logic [N_CH-1:0]  busy,
  output logic [PTR_W-1:0] ptr,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [HOLD_W-1:0] hold [N_CH];

  logic [PTR_W:0]   cand;
  logic [PTR_W:0]   inc;
  logic             en_found;
  logic             free_found;
  logic [PTR_W-1:0] en_idx;
  logic [PTR_W-1:0] free_idx;
  logic [PTR_W-1:0] sel_idx;
  logic [PTR_W-1:0] ptr_nxt;
  logic             dispatch;
  logic             ptr_upd;
  logic             drop;

  // A channel is busy while its hold-off counter is non-zero
  always_comb begin
    busy = '0;
    for (int k = 0; k < N_CH; k++) begin
      busy[k] = (hold[k] != '0);
    end
  end

  // Scan from ptr with wrap; find first enabled and first enabled-and-free channel
  always_comb begin
    en_found   = 1'b0;
    free_found = 1'b0;
    en_idx     = '0;
    free_idx   = '0;
    cand       = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CH)) begin
        cand = cand - (PTR_W+1)'(N_CH);
      end
      if (!en_found && ch_en[cand[PTR_W-1:0]]) begin
        en_found = 1'b1;
        en_idx   = cand[PTR_W-1:0];
      end
      if (!free_found && ch_en[cand[PTR_W-1:0]] && !busy[cand[PTR_W-1:0]]) begin
        free_found = 1'b1;
        free_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Decide dispatch or drop for this cycle's pulse and where the pointer moves
  always_comb begin
    dispatch = 1'b0;
    ptr_upd  = 1'b0;
    sel_idx  = '0;
    if (in) begin
      if (mode) begin
        if (free_found) begin
          dispatch = 1'b1;
          ptr_upd  = 1'b1;
          sel_idx  = free_idx;
        end
      end else if (en_found) begin
        // Strict rotation advances past the target even when it drops the pulse
        sel_idx  = en_idx;
        ptr_upd  = 1'b1;
        dispatch = !busy[en_idx];
      end
    end
    drop    = in && !dispatch;
    inc     = {1'b0, sel_idx} + (PTR_W+1)'(1);
    ptr_nxt = (inc == (PTR_W+1)'(N_CH)) ? '0 : inc[PTR_W-1:0];
  end

  // Register the one-hot dispatch pulse and the round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      ptr <= '0;
    end else begin
      out <= dispatch ? (N_CH'(1) << sel_idx) : '0;
      if (ptr_upd) begin
        ptr <= ptr_nxt;
      end
    end
  end

  // Hold-off counters: reload on dispatch, otherwise count down to zero
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        hold[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (dispatch && (sel_idx == PTR_W'(k))) begin
          hold[k] <= HOLD_W'(HOLD);
        end else if (hold[k] != '0) begin
          hold[k] <= hold[k] - 1'b1;
        end
      end
    end
  end

  // Saturating sent/drop counters; clear takes priority over counting
  always_ff @(posedge clk) begin
    if (reset || clr_cnt) begin
      sent_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (dispatch && (sent_cnt != '1)) begin
        sent_cnt <= sent_cnt + 1'b1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule
